// File: rtl/hps_master_p2b_encoder_if.sv
// Packet-beat input and encoded byte-stream output of the HPS master packets-to-bytes encoder.
// slave: the encoder; master: the packet source that also sinks the byte stream.
interface hps_master_p2b_encoder_if #(
  parameter int unsigned CHANNEL_W = 8
) ();
  logic                 in_ready;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic [CHANNEL_W-1:0] in_channel;
  logic                 in_startofpacket;
  logic                 in_endofpacket;
  logic                 out_ready;
  logic                 out_valid;
  logic [7:0]           out_data;

  modport master (
    input  in_ready,
    output in_valid,
    output in_data,
    output in_channel,
    output in_startofpacket,
    output in_endofpacket,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    output in_ready,
    input  in_valid,
    input  in_data,
    input  in_channel,
    input  in_startofpacket,
    input  in_endofpacket,
    input  out_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/hps_master_p2b_encoder.sv
// Avalon-ST packets-to-bytes encoder: in-band SOP/EOP/channel markers with 0x7D escaping.
// Define P2B_CHANNEL_EN to emit channel headers; otherwise in_channel is ignored.
module hps_master_p2b_encoder #(
  parameter int unsigned CHANNEL_W = 8
) (
  input logic                      clk,
  input logic                      reset_n,
  hps_master_p2b_encoder_if.slave  bus
);

  // State value doubles as the position of its byte within a beat's emit order.
`ifdef P2B_CHANNEL_EN
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StChMark  = 3'd1,
    StChEsc   = 3'd2,
    StChVal   = 3'd3,
    StSopMark = 3'd4,
    StEopMark = 3'd5,
    StDEsc    = 3'd6,
    StDVal    = 3'd7
  } state_e;
  localparam int unsigned LastSt = 7;
`else
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSopMark = 3'd1,
    StEopMark = 3'd2,
    StDEsc    = 3'd3,
    StDVal    = 3'd4
  } state_e;
  localparam int unsigned LastSt = 4;
`endif

  typedef logic [LastSt:0] mask_t;

  function automatic logic is_special(logic [7:0] b);
    return (b >= 8'h7A) && (b <= 8'h7D);
  endfunction

  function automatic logic [7:0] esc_val(logic [7:0] b);
    return is_special(b) ? (b ^ 8'h20) : b;
  endfunction

  function automatic mask_t beat_mask(logic sop, logic eop, logic [7:0] d);
    mask_t m;
    m            = '0;
    m[StSopMark] = sop;
    m[StEopMark] = eop;
    m[StDEsc]    = is_special(d);
    m[StDVal]    = 1'b1;
    return m;
  endfunction

  // First enabled position strictly after st; StIdle once the beat is exhausted.
  function automatic state_e next_after(state_e st, mask_t m);
    state_e nx;
    nx = StIdle;
    for (int i = LastSt; i >= 1; i--) begin
      if ((i > int'(st)) && m[3'(i)]) nx = state_e'(3'(i));
    end
    return nx;
  endfunction

  function automatic logic [7:0] byte_of(state_e st, logic [7:0] d
`ifdef P2B_CHANNEL_EN
                                         , logic [7:0] ch
`endif
                                         );
    logic [7:0] b;
    case (st)
`ifdef P2B_CHANNEL_EN
      StChMark:  b = 8'h7C;
      StChEsc:   b = 8'h7D;
      StChVal:   b = esc_val(ch);
`endif
      StSopMark: b = 8'h7A;
      StEopMark: b = 8'h7B;
      StDEsc:    b = 8'h7D;
      StDVal:    b = esc_val(d);
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  state_e     state_q, first_st, succ_st;
  logic [7:0] data_q, out_data_q, first_byte, succ_byte;
  logic       sop_q, eop_q, out_valid_q, accept;
  mask_t      first_mask, succ_mask;

`ifdef P2B_CHANNEL_EN
  logic [7:0] ch_q, last_channel_q, in_ch8;
  logic       ch_sent_q, need_ch_q, in_need_ch;
`else
  logic [CHANNEL_W-1:0] unused_channel;
  assign unused_channel = bus.in_channel;
`endif

  assign bus.in_ready  = (state_q == StIdle) || ((state_q == StDVal) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    first_mask = beat_mask(bus.in_startofpacket, bus.in_endofpacket, bus.in_data);
    succ_mask  = beat_mask(sop_q, eop_q, data_q);
`ifdef P2B_CHANNEL_EN
    in_ch8                 = '0;
    in_ch8[CHANNEL_W-1:0]  = bus.in_channel;
    in_need_ch             = bus.in_startofpacket && (!ch_sent_q || (in_ch8 != last_channel_q));
    first_mask[StChMark]   = in_need_ch;
    first_mask[StChEsc]    = in_need_ch && is_special(in_ch8);
    first_mask[StChVal]    = in_need_ch;
    succ_mask[StChMark]    = need_ch_q;
    succ_mask[StChEsc]     = need_ch_q && is_special(ch_q);
    succ_mask[StChVal]     = need_ch_q;
`endif
    first_st = next_after(StIdle, first_mask);
    succ_st  = next_after(state_q, succ_mask);
`ifdef P2B_CHANNEL_EN
    first_byte = byte_of(first_st, bus.in_data, in_ch8);
    succ_byte  = byte_of(succ_st, data_q, ch_q);
`else
    first_byte = byte_of(first_st, bus.in_data);
    succ_byte  = byte_of(succ_st, data_q);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      out_valid_q    <= 1'b0;
      out_data_q     <= 8'h00;
      data_q         <= 8'h00;
      sop_q          <= 1'b0;
      eop_q          <= 1'b0;
`ifdef P2B_CHANNEL_EN
      ch_q           <= 8'h00;
      last_channel_q <= 8'h00;
      ch_sent_q      <= 1'b0;
      need_ch_q      <= 1'b0;
`endif
    end else begin
`ifdef P2B_CHANNEL_EN
      if ((state_q == StChVal) && bus.out_ready) begin
        last_channel_q <= ch_q;
        ch_sent_q      <= 1'b1;
      end
`endif
      if (accept) begin
        state_q     <= first_st;
        out_valid_q <= 1'b1;
        out_data_q  <= first_byte;
        data_q      <= bus.in_data;
        sop_q       <= bus.in_startofpacket;
        eop_q       <= bus.in_endofpacket;
`ifdef P2B_CHANNEL_EN
        ch_q        <= in_ch8;
        need_ch_q   <= in_need_ch;
`endif
      end else if ((state_q != StIdle) && bus.out_ready) begin
        state_q     <= succ_st;
        out_valid_q <= (succ_st != StIdle);
        out_data_q  <= succ_byte;
      end
    end
  end

endmodule

// File: tb/tb_hps_master_p2b_encoder.sv
// Bench for hps_master_p2b_encoder: byte-queue reference model, directed scenarios, random beats.
module tb_hps_master_p2b_encoder;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hps_master_p2b_encoder_if #(.CHANNEL_W(CW)) bus ();

  hps_master_p2b_encoder #(.CHANNEL_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] exp_q[$];   // bytes of the current beat still to be transferred, front = presented
  logic [7:0] xfer_q[$];  // bytes the sink has accepted
  logic [7:0] seq[$];
  logic       m_ch_sent;
  logic [7:0] m_last_ch;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       acc;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_esc(input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endtask

  task automatic model_beat(input logic sop, input logic eop, input logic [7:0] d,
                            input logic [CW-1:0] ch);
    logic [7:0] c8;
    c8 = 8'(ch);
`ifdef P2B_CHANNEL_EN
    if (sop && (!m_ch_sent || c8 != m_last_ch)) begin
      exp_q.push_back(8'h7C);
      push_esc(c8);
      m_ch_sent = 1'b1;
      m_last_ch = c8;
    end
`endif
    if (sop) exp_q.push_back(8'h7A);
    if (eop) exp_q.push_back(8'h7B);
    push_esc(d);
  endtask

  task automatic model_reset();
    exp_q.delete();
    xfer_q.delete();
    m_ch_sent = 1'b0;
    m_last_ch = 8'h00;
  endtask

  // One clock: starts and ends at a falling edge.
  task automatic cycle(input logic iv, input logic sop, input logic eop, input logic [7:0] d,
                       input logic [CW-1:0] ch, input logic ordy, output logic accepted);
    logic exp_rdy;
    bus.in_valid         = iv;
    bus.in_startofpacket = sop;
    bus.in_endofpacket   = eop;
    bus.in_data          = d;
    bus.in_channel       = ch;
    bus.out_ready        = ordy;
    #1;
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    check("out_valid", 8'(bus.out_valid), 8'(exp_q.size() != 0));
    check("in_ready", 8'(bus.in_ready), 8'(exp_rdy));
    if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q[0]);
    accepted = iv && exp_rdy;
    @(posedge clk);
    if (exp_q.size() != 0 && ordy) xfer_q.push_back(exp_q.pop_front());
    if (accepted) model_beat(sop, eop, d, ch);
    @(negedge clk);
  endtask

  task automatic send(input logic sop, input logic eop, input logic [7:0] d,
                      input logic [CW-1:0] ch);
    logic a;
    a = 1'b0;
    for (int k = 0; k < 50 && !a; k++) cycle(1'b1, sop, eop, d, ch, 1'b1, a);
    if (!a) check("send_timeout", 8'h00, 8'h01);
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b1, a);
    if (exp_q.size() != 0) check("drain_timeout", 8'(exp_q.size()), 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b1, a);
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] want[$]);
    check({tag, "_len"}, 8'(xfer_q.size()), 8'(want.size()));
    for (int i = 0; i < want.size() && i < xfer_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), xfer_q[i], want[i]);
    xfer_q.delete();
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", 8'(bus.out_valid), 8'h00);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_in_ready", 8'(bus.in_ready), 8'h01);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] chs[3];
    chs = '{8'h00, 8'h01, 8'h7B};
    reset_n              = 1'b1;
    bus.in_valid         = 1'b0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket   = 1'b0;
    bus.in_data          = 8'h00;
    bus.in_channel       = '0;
    bus.out_ready        = 1'b0;
    #2;
    async_reset();

    // Single-beat packet
    send(1'b1, 1'b1, 8'h41, 8'h00);
    drain();
`ifdef P2B_CHANNEL_EN
    seq = {8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h41};
`else
    seq = {8'h7A, 8'h7B, 8'h41};
`endif
    check_xfer("single", seq);

    // Two-beat packet, same channel: no header, second beat accepted back-to-back
    send(1'b1, 1'b0, 8'h10, 8'h00);
    send(1'b0, 1'b1, 8'h20, 8'h00);
    drain();
    seq = {8'h7A, 8'h10, 8'h7B, 8'h20};
    check_xfer("two_beat", seq);

    // Escaped channel and data
    send(1'b1, 1'b0, 8'h7D, 8'h7A);
    drain();
`ifdef P2B_CHANNEL_EN
    seq = {8'h7C, 8'h7D, 8'h5A, 8'h7A, 8'h7D, 8'h5D};
`else
    seq = {8'h7A, 8'h7D, 8'h5D};
`endif
    check_xfer("escape", seq);

    // Back-pressure while 0x7A is presented
    send(1'b1, 1'b1, 8'h55, 8'h00);
    for (int k = 0; k < 10 && exp_q.size() != 0 && exp_q[0] != 8'h7A; k++)
      cycle(1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b1, acc);
    check("hold_front", exp_q[0], 8'h7A);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 8'h99, '0, 1'b0, acc);
    drain();
`ifdef P2B_CHANNEL_EN
    seq = {8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h55};
`else
    seq = {8'h7A, 8'h7B, 8'h55};
`endif
    check_xfer("hold", seq);

    // Reset mid-sequence after the first byte transfers
    send(1'b1, 1'b0, 8'h66, 8'h03);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b1, acc);
`ifdef P2B_CHANNEL_EN
    check("pre_reset_first", xfer_q[0], 8'h7C);
`else
    check("pre_reset_first", xfer_q[0], 8'h7A);
`endif
    async_reset();
    send(1'b1, 1'b1, 8'h22, 8'h00);
    drain();
`ifdef P2B_CHANNEL_EN
    seq = {8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h22};
`else
    seq = {8'h7A, 8'h7B, 8'h22};
`endif
    check_xfer("after_reset", seq);

    // Payload 0x7C
    send(1'b1, 1'b1, 8'h7C, 8'h05);
    drain();
`ifdef P2B_CHANNEL_EN
    seq = {8'h7C, 8'h05, 8'h7A, 8'h7B, 8'h7D, 8'h5C};
`else
    seq = {8'h7A, 8'h7B, 8'h7D, 8'h5C};
`endif
    check_xfer("payload_7c", seq);

    // Random beats and back-pressure
    for (int k = 0; k < 400; k++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 1) == 1) ? 8'(8'h7A + 8'($urandom_range(0, 3))) : 8'($urandom);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
            CW'(chs[$urandom_range(0, 2)]), 1'($urandom_range(0, 3) != 0), acc);
    end
    drain();
    xfer_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hps_master_p2b_encoder.md
# hps_master_p2b_encoder

Avalon-ST packets-to-bytes encoder for the HPS master bridge transmit path. Accepts one packet beat per handshake (8-bit data, channel, start/end-of-packet) and serialises it into a flat byte stream. Framing is in-band: SOP, EOP and channel markers, with escaping of special characters. It is the sending end for the bridge's bytes-to-packets decoder and channel adapter, and it drives the byte-stream side of the host link.

## Interface
- `CHANNEL_W`, default 8: width of `in_channel`; legal range 1..8. The value is zero-extended to 8 bits when emitted.
- `clk` input, 1: sole clock; all logic is rising-edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `in_ready` output, 1: encoder can accept a packet beat.
- `in_valid` input, 1: packet beat present.
- `in_data` input, 8: payload byte.
- `in_channel` input, CHANNEL_W: channel number; sampled only on SOP beats.
- `in_startofpacket` input, 1: first beat of packet.
- `in_endofpacket` input, 1: last beat of packet.
- `out_ready` input, 1: byte sink ready.
- `out_valid` output, 1: encoded byte present.
- `out_data` output, 8: encoded byte.

## Operation
- Special bytes:
  - `0x7A` is the SOP marker.
  - `0x7B` is the EOP marker.
  - `0x7C` is the channel marker.
  - `0x7D` is the escape byte.
- Any payload or channel byte in the range 0x7A..0x7D is sent as `0x7D` followed by (byte XOR 0x20).
- Beat transfer occurs when `in_valid && in_ready`. The beat's data, flags and channel are captured into holding registers.
- Per-beat emit order, with optional items skipped:
  1. Channel: `0x7C` then the channel byte, escaped if needed. Emitted only on SOP beats when the channel differs from the last sent channel, or when no channel has been sent since reset.
  2. `0x7A`, if SOP.
  3. `0x7B`, if EOP.
  4. Data byte, escaped if needed.
- Single-beat packets emit `7A 7B dd` (plus the channel header if one is required).
- FSM states: IDLE, CH_MARK, CH_ESC, CH_VAL, SOP_MARK, EOP_MARK, D_ESC, D_VAL.
  - IDLE plus an accepted beat moves to the first applicable state.
  - Each non-IDLE state advances only when `out_ready` is high.
  - D_VAL with `out_ready` goes to IDLE, or directly into the next beat's first state if a new beat is accepted in the same cycle.
- `in_ready = (state==IDLE) || (state==D_VAL && out_ready)`. This allows back-to-back unescaped data at 1 byte/cycle.
- `last_channel` and `ch_sent` update when the channel value byte is accepted by the sink.
- Non-SOP beats never emit a channel header, even if `in_channel` changes.
- SOP/EOP protocol violations (missing SOP, double SOP) are not checked. Markers are emitted exactly as flagged.

## Timing
- Reset values:
  - state = IDLE, `out_valid` = 0, `out_data` = 0x00, `in_ready` = 1.
  - `ch_sent` = 0, `last_channel` = 0.
- `out_valid` and `out_data` are registered.
- Latency: a beat accepted at edge N presents its first encoded byte from cycle N+1.
- While `out_valid && !out_ready`, `out_data` holds stable and the state does not advance.
- `out_valid` never drops without a completed transfer, except on reset.
- A reset asserted mid-sequence discards the partial sequence:
  - `out_valid` goes to 0 immediately (asynchronous).
  - `ch_sent` is cleared, so the next SOP re-emits the channel header.
- `in_ready` is combinational from state and `out_ready`. It never depends on `in_valid`.

## Configuration
- `P2B_CHANNEL_EN` defined: channel header logic present as described above.
- `P2B_CHANNEL_EN` undefined:
  - `in_channel` is ignored.
  - CH_* states, `last_channel` and `ch_sent` are removed.
  - `0x7C` is only ever emitted as escaped payload (`7D 5C`).

## Test plan
- Reset, then beat SOP+EOP, data 0x41, channel 0, `out_ready`=1 → `7C 00 7A 7B 41`; `in_ready` returns high on the cycle `41` transfers.
- Follow with a 2-beat packet, channel 0, data 0x10 then 0x20 → `7A 10 7B 20`, no channel header; the second beat is accepted on the same cycle `10` transfers.
- SOP beat with channel 0x7A (CHANNEL_W=8) and data 0x7D → `7C 7D 5A 7A 7D 5D`.
- Hold `out_ready` low for 3 cycles while `out_data`=0x7A → `out_data`/`out_valid` stable at 0x7A/1 and `in_ready`=0 throughout; the sequence then resumes unchanged.
- Assert `reset_n`=0 after `7C` transfers → `out_valid`=0 immediately; after release, an SOP beat with channel 0 re-emits `7C 00`.
- Build without `P2B_CHANNEL_EN`; SOP+EOP beat with data 0x7C and channel 5 → `7A 7B 7D 5C`, no channel header.
